// File: rtl/memblock_pkg.sv
// Shared types and helpers for the multi-port memory block.
package memblock_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Address width; a 2-word memory still needs one address bit.
    function automatic int calc_aw(input int depth);
        return ($clog2(depth) > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/memblock_rdport.sv
// One read port: address mux, zero-forcing, optional output register and write forwarding.
module memblock_rdport
    import memblock_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int RD_REG = 0,
    parameter int BYPASS = 1,
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic             wr_ok,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_word,
    output logic [WIDTH-1:0] dout
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic             in_range;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] fwd;
    logic             unused;

    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign raw      = in_range ? mem[addr] : '0;
    // Forwarding returns the byte-merged word that this same edge writes.
    assign fwd      = ((BYPASS != 0) && wr_ok && (wr_addr == addr)) ? wr_word : raw;
    assign unused   = &{1'b0, clk, rst, en, fwd};

    generate
        if (RD_REG != 0) begin : g_reg
            logic [WIDTH-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    dout_q <= '0;
                end else if (en) begin
                    dout_q <= (busy || !in_range) ? '0 : fwd;
                end
            end

            assign dout = dout_q;
        end else begin : g_comb
            assign dout = (busy || !in_range) ? '0 : raw;
        end
    endgenerate

endmodule

// File: rtl/memblock_mp.sv
// Byte-writable memory with one write port, NRD read ports and a sweeping clear engine.
module memblock_mp
    import memblock_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int NRD    = 2,
    parameter int RD_REG = 0,
    parameter int BYPASS = 1,
    localparam int AW    = calc_aw(DEPTH),
    localparam int NB    = WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 busy,
    input  logic                 we0,
    input  logic [AW-1:0]        wr_addr0,
    input  logic [WIDTH-1:0]     wr_din0,
    input  logic [NB-1:0]        wr_be0,
    output logic                 wr_err,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_dout
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    state_t           state, state_nxt;
    logic [AW-1:0]    ptr, ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_in_range;
    logic             wr_ok;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_word;

    assign busy        = (state == CLEAR);
    assign wr_in_range = ({1'b0, wr_addr0} < DEPTH_W);
    assign wr_ok       = we0 && !busy && wr_in_range;
    assign wr_old      = wr_in_range ? mem[wr_addr0] : '0;

    always_comb begin
        wr_word = wr_old;
        for (int b = 0; b < NB; b++) begin
            if (wr_be0[b]) begin
                wr_word[b*8 +: 8] = wr_din0[b*8 +: 8];
            end
        end
    end

    // Reset lands in CLEAR so that every word is swept after release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= CLEAR;
            ptr    <= '0;
            wr_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            wr_err <= we0 && !wr_ok;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                if (ptr == PTR_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (busy) begin
                mem[ptr] <= '0;
            end else if (wr_ok) begin
                mem[wr_addr0] <= wr_word;
            end
        end
    end

    generate
        for (genvar p = 0; p < NRD; p++) begin : g_rd
            memblock_rdport #(
                .WIDTH  (WIDTH),
                .DEPTH  (DEPTH),
                .RD_REG (RD_REG),
                .BYPASS (BYPASS)
            ) u_rdport (
                .clk     (clk),
                .rst     (rst),
                .busy    (busy),
                .mem     (mem),
                .en      (rd_en[p]),
                .addr    (rd_addr[p*AW +: AW]),
                .wr_ok   (wr_ok),
                .wr_addr (wr_addr0),
                .wr_word (wr_word),
                .dout    (rd_dout[p*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_memblock_mp.sv
// Bench for memblock_mp: four configurations share one stimulus stream and a behavioural model.
module tb_memblock_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        we0;
    logic [2:0]  wr_addr0;
    logic [31:0] wr_din0;
    logic [3:0]  wr_be0;
    logic [1:0]  rd_en;
    logic [5:0]  rd_addr;

    logic        busy_a, busy_b, busy_c, busy_d;
    logic        err_a, err_b, err_c, err_d;
    logic [63:0] dout_a, dout_b, dout_c, dout_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: async read, b: registered with forwarding, c: registered without, d: async with DEPTH=6
    memblock_mp #(.WIDTH(32), .DEPTH(8), .NRD(2), .RD_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a), .we0(we0), .wr_addr0(wr_addr0),
        .wr_din0(wr_din0), .wr_be0(wr_be0), .wr_err(err_a), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_dout(dout_a));
    memblock_mp #(.WIDTH(32), .DEPTH(8), .NRD(2), .RD_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b), .we0(we0), .wr_addr0(wr_addr0),
        .wr_din0(wr_din0), .wr_be0(wr_be0), .wr_err(err_b), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_dout(dout_b));
    memblock_mp #(.WIDTH(32), .DEPTH(8), .NRD(2), .RD_REG(1), .BYPASS(0)) dut_c (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_c), .we0(we0), .wr_addr0(wr_addr0),
        .wr_din0(wr_din0), .wr_be0(wr_be0), .wr_err(err_c), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_dout(dout_c));
    memblock_mp #(.WIDTH(32), .DEPTH(6), .NRD(2), .RD_REG(0), .BYPASS(1)) dut_d (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_d), .we0(we0), .wr_addr0(wr_addr0),
        .wr_din0(wr_din0), .wr_be0(wr_be0), .wr_err(err_d), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_dout(dout_d));

    // Reference model: word arrays plus a count of clear edges still owed.
    logic [31:0] m8 [8] = '{default: 32'h0};
    logic [31:0] m6 [8] = '{default: 32'h0};
    int          left8 = 8;
    int          left6 = 6;
    logic        e8 = 1'b0;
    logic        e6 = 1'b0;
    logic [31:0] rb [2] = '{default: 32'h0};
    logic [31:0] rc [2] = '{default: 32'h0};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) old[b*8 +: 8] = din[b*8 +: 8];
        return old;
    endfunction

    task automatic model_edge();
        logic        acc8, acc6;
        logic [31:0] nw8;
        int          a;
        if (!rst) begin
            left8 = 8; left6 = 6; e8 = 1'b0; e6 = 1'b0;
            rb[0] = '0; rb[1] = '0; rc[0] = '0; rc[1] = '0;
            return;
        end
        acc8 = we0 && (left8 == 0);
        acc6 = we0 && (left6 == 0) && (wr_addr0 < 6);
        nw8  = merge(m8[wr_addr0], wr_din0, wr_be0);
        for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) begin
                a = int'(rd_addr[p*3 +: 3]);
                if (left8 > 0) begin
                    rb[p] = '0; rc[p] = '0;
                end else begin
                    rc[p] = m8[a];
                    rb[p] = (acc8 && a == int'(wr_addr0)) ? nw8 : m8[a];
                end
            end
        end
        e8 = we0 && !acc8;
        e6 = we0 && !acc6;
        if (acc8) m8[wr_addr0] = nw8;
        if (acc6) m6[wr_addr0] = merge(m6[wr_addr0], wr_din0, wr_be0);
        if (left8 > 0) begin m8[8 - left8] = '0; left8--; end else if (clr_req) left8 = 8;
        if (left6 > 0) begin m6[6 - left6] = '0; left6--; end else if (clr_req) left6 = 6;
    endtask

    always @(posedge clk) model_edge();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        int a;
        chk("busy_a", 32'(busy_a), 32'(left8 > 0));
        chk("busy_b", 32'(busy_b), 32'(left8 > 0));
        chk("busy_c", 32'(busy_c), 32'(left8 > 0));
        chk("busy_d", 32'(busy_d), 32'(left6 > 0));
        chk("err_a", 32'(err_a), 32'(e8));
        chk("err_b", 32'(err_b), 32'(e8));
        chk("err_c", 32'(err_c), 32'(e8));
        chk("err_d", 32'(err_d), 32'(e6));
        for (int p = 0; p < 2; p++) begin
            a = int'(rd_addr[p*3 +: 3]);
            chk($sformatf("model_dout_a%0d", p), dout_a[p*32 +: 32], (left8 > 0) ? 32'h0 : m8[a]);
            chk($sformatf("model_dout_b%0d", p), dout_b[p*32 +: 32], rb[p]);
            chk($sformatf("model_dout_c%0d", p), dout_c[p*32 +: 32], rc[p]);
            chk($sformatf("model_dout_d%0d", p), dout_d[p*32 +: 32],
                (left6 > 0 || a >= 6) ? 32'h0 : m6[a]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic w,
                                 input logic [2:0] wa, input logic [31:0] wd, input logic [3:0] be,
                                 input logic [1:0] en, input logic [2:0] ra1, input logic [2:0] ra0);
        rst = r; clr_req = c; we0 = w; wr_addr0 = wa; wr_din0 = wd; wr_be0 = be;
        rd_en = en; rd_addr = {ra1, ra0};
        cycle();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_a && n < 40) begin
            cycle();
            n++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [31:0] din;
        logic [3:0]  be;
        logic [2:0]  ra0, ra1;
        logic [31:0] exp0, exp1;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        tbl[0] = '{1'b1, 3'd3, 32'hFFFFFFFF, 4'hF, 3'd3, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[1] = '{1'b1, 3'd3, 32'h12345678, 4'h5, 3'd3, 3'd0, 32'hFF34FF78, 32'h00000000};
        tbl[2] = '{1'b1, 3'd3, 32'h00000000, 4'h0, 3'd3, 3'd3, 32'hFF34FF78, 32'hFF34FF78};
        tbl[3] = '{1'b1, 3'd0, 32'hAABBCCDD, 4'hA, 3'd0, 3'd3, 32'hAA00CC00, 32'hFF34FF78};
        tbl[4] = '{1'b1, 3'd7, 32'h11223344, 4'hF, 3'd7, 3'd0, 32'h11223344, 32'hAA00CC00};
        tbl[5] = '{1'b0, 3'd0, 32'h00000000, 4'h0, 3'd7, 3'd7, 32'h11223344, 32'h11223344};

        rst = 1'b0; clr_req = 1'b0; we0 = 1'b0; wr_addr0 = '0; wr_din0 = '0; wr_be0 = '0;
        rd_en = '0; rd_addr = '0;

        // Reset held for two edges, then a full sweep
        cycle();
        cycle();
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_dout_b", dout_b[31:0], 32'h0);
        rst = 1'b1;
        wait_idle(n);
        chk("sweep_len", n, 8);
        for (int i = 0; i < 8; i += 2) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 3'(i + 1), 3'(i));
            chk($sformatf("swept_%0d", i), dout_a[31:0], 32'h0);
            chk($sformatf("swept_%0d", i + 1), dout_a[63:32], 32'h0);
        end

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, tbl[i].we, tbl[i].wa, tbl[i].din, tbl[i].be, 2'b00,
                          tbl[i].ra1, tbl[i].ra0);
            chk($sformatf("vec%0d_p0", i), dout_a[31:0], tbl[i].exp0);
            chk($sformatf("vec%0d_p1", i), dout_a[63:32], tbl[i].exp1);
            chk($sformatf("vec%0d_err", i), 32'(err_a), 32'd0);
        end

        // Same-edge write and read of address 5
        applyStimulus(1, 0, 1, 3'd5, 32'hA5A5A5A5, 4'hF, 2'b10, 3'd5, 3'd0);
        chk("bypass_on", dout_b[63:32], 32'hA5A5A5A5);
        chk("bypass_off", dout_c[63:32], 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b11, 3'd5, 3'd5);
        chk("shared_b0", dout_b[31:0], 32'hA5A5A5A5);
        chk("shared_c1", dout_c[63:32], 32'hA5A5A5A5);
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 3'd3, 3'd3);
        chk("hold_b1", dout_b[63:32], 32'hA5A5A5A5);
        chk("hold_c0", dout_c[31:0], 32'hA5A5A5A5);

        // Write while clearing; repeated clr_req must not extend the sweep
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);
        chk("clr_busy", 32'(busy_a), 32'd1);
        applyStimulus(1, 1, 1, 3'd2, 32'h1, 4'hF, 2'b00, 3'd0, 3'd0);
        chk("clr_err_pulse", 32'(err_a), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);
        chk("clr_err_end", 32'(err_a), 32'd0);
        wait_idle(n);
        chk("clr_len", n, 6);
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 3'd5, 3'd2);
        chk("clr_addr2", dout_a[31:0], 32'h0);
        chk("clr_addr5", dout_a[63:32], 32'h0);

        // Reset after four sweep edges restarts the sweep
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);
        repeat (4) applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);
        chk("mid_busy", 32'(busy_a), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);
        rst = 1'b1;
        wait_idle(n);
        chk("mid_len", n, 8);

        // Out-of-range write and read on the 6-word instance
        applyStimulus(1, 0, 1, 3'd1, 32'hCAFEF00D, 4'hF, 2'b00, 3'd0, 3'd0);
        applyStimulus(1, 0, 1, 3'd7, 32'hDEADBEEF, 4'hF, 2'b00, 3'd6, 3'd6);
        chk("oor_err_d", 32'(err_d), 32'd1);
        chk("oor_err_a", 32'(err_a), 32'd0);
        chk("oor_read_d", dout_d[31:0], 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 3'd6, 3'd6);
        chk("oor_err_end", 32'(err_d), 32'd0);
        for (int i = 0; i < 6; i += 2) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 3'(i + 1), 3'(i));
            chk($sformatf("oor_keep_%0d", i), dout_d[31:0], (i == 1) ? 32'hCAFEF00D : 32'h0);
            chk($sformatf("oor_keep_%0d", i + 1), dout_d[63:32],
                (i + 1 == 1) ? 32'hCAFEF00D : 32'h0);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0,
                          1'($urandom), 3'($urandom), $urandom, 4'($urandom),
                          2'($urandom), 3'($urandom), 3'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
